// File: rtl/mesh_readback_sequencer.sv
// ---------------------------------------------------------------------------
// mesh_readback_sequencer
//
// Reads a completed mesh result (TOTAL_ELEMS words, linear addresses
// 0..TOTAL_ELEMS-1) and streams it out on a valid/ready interface. The words
// pass through a small FIFO. Reads are issued only when the FIFO has room,
// so backpressure never drops a word.
//
// Ports
//   clk_i                       single clock, rising edge
//   rst_i                       synchronous active-high reset
//   start_i                     arm a readback job (honoured in IDLE / ERROR)
//   abort_i                     cancel the job in progress
//   mesh_collection_complete_i  mesh results are ready for reading
//   mesh_read_enable_o          mesh read request (1-cycle latency)
//   mesh_read_addr_o            mesh linear read address
//   mesh_read_data_i            mesh read data
//   mesh_read_valid_i           mesh read data valid
//   m_valid_o / m_data_o        output stream valid and data (FIFO head)
//   m_last_o                    high with the word read from the last address
//   m_ready_i                   output stream ready
//   busy_o                      high in every state except IDLE
//   done_o                      one-cycle pulse on the DRAIN -> IDLE transition
//   error_o                     sticky protocol error flag
// ---------------------------------------------------------------------------
module mesh_readback_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int TOTAL_ELEMS = 1024,
    parameter int ADDR_W      = $clog2(TOTAL_ELEMS),
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic                  mesh_collection_complete_i,
    output logic                  mesh_read_enable_o,
    output logic [ADDR_W-1:0]     mesh_read_addr_o,
    input  logic [DATA_WIDTH-1:0] mesh_read_data_i,
    input  logic                  mesh_read_valid_i,
    output logic                  m_valid_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_last_o,
    input  logic                  m_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = PTR_W + 2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL_ELEMS - 1);

    localparam logic [2:0] ST_IDLE          = 3'd0;
    localparam logic [2:0] ST_WAIT_COMPLETE = 3'd1;
    localparam logic [2:0] ST_STREAM        = 3'd2;
    localparam logic [2:0] ST_DRAIN         = 3'd3;
    localparam logic [2:0] ST_ERROR         = 3'd4;

    logic [2:0]            state;
    logic [ADDR_W-1:0]     read_addr;
    logic                  in_flight;
    logic                  error_q;

    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic                  fifo_last [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;

    logic                  read_missing;
    logic                  stray_valid;
    logic                  protocol_error;
    logic [CW-1:0]         credit_used;
    logic                  credit_ok;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic                  drain_done;
    logic                  aborting;

    // A read issued last cycle must return now; a return with nothing
    // outstanding while a job is active is equally a protocol violation.
    assign read_missing   = in_flight && !mesh_read_valid_i;
    assign stray_valid    = mesh_read_valid_i && !in_flight &&
                            (state == ST_WAIT_COMPLETE || state == ST_STREAM ||
                             state == ST_DRAIN);
    assign protocol_error = read_missing || stray_valid;

    assign aborting = abort_i && (state != ST_IDLE);

    // Credit counts the outstanding read as already occupying a FIFO slot.
    // A pop in the same cycle is not credited, which keeps the check purely
    // registered-state based while still allowing one read per cycle.
    assign credit_used = CW'(count) + CW'(in_flight);
    assign credit_ok   = credit_used < CW'(FIFO_DEPTH);

    assign issue = (state == ST_STREAM) && !abort_i && !protocol_error && credit_ok;
    assign push  = in_flight && mesh_read_valid_i && !abort_i;
    assign pop   = m_valid_o && m_ready_i;

    assign drain_done = (state == ST_DRAIN) && (count == '0) && !in_flight &&
                        !abort_i && !protocol_error;

    assign mesh_read_enable_o = issue;
    assign mesh_read_addr_o   = read_addr;
    assign m_valid_o          = (count != '0);
    assign m_data_o           = m_valid_o ? fifo_data[rd_ptr] : '0;
    assign m_last_o           = m_valid_o && fifo_last[rd_ptr];
    assign busy_o             = (state != ST_IDLE);
    assign done_o             = drain_done;
    assign error_o            = error_q;

    // Control FSM, address counter, in-flight flag and sticky error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            read_addr <= '0;
            in_flight <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            in_flight <= issue;
            if (issue) begin
                read_addr <= read_addr + ADDR_W'(1);
            end

            if (aborting) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_i) begin
                            state     <= ST_WAIT_COMPLETE;
                            read_addr <= '0;
                            error_q   <= 1'b0;
                        end
                    end
                    ST_WAIT_COMPLETE: begin
                        if (protocol_error) begin
                            state   <= ST_ERROR;
                            error_q <= 1'b1;
                        end else if (mesh_collection_complete_i) begin
                            state <= ST_STREAM;
                        end
                    end
                    ST_STREAM: begin
                        if (protocol_error) begin
                            state   <= ST_ERROR;
                            error_q <= 1'b1;
                        end else if (issue && read_addr == LAST_ADDR) begin
                            state <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if (protocol_error) begin
                            state   <= ST_ERROR;
                            error_q <= 1'b1;
                        end else if (drain_done) begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_ERROR: begin
                        if (start_i) begin
                            state     <= ST_WAIT_COMPLETE;
                            read_addr <= '0;
                            error_q   <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // FIFO pointers and occupancy; abort and protocol errors flush everything.
    always_ff @(posedge clk_i) begin
        if (rst_i || aborting || protocol_error) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage only; the last flag travels with each word. read_addr has
    // already advanced, so the returning word came from read_addr - 1.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data[wr_ptr] <= mesh_read_data_i;
            fifo_last[wr_ptr] <= (read_addr - ADDR_W'(1)) == LAST_ADDR;
        end
    end

endmodule

// File: tb/tb_mesh_readback_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mesh_readback_sequencer
//
// Drives readback jobs into mesh_readback_sequencer with a 1-cycle mesh
// memory (data = address + 100) and checks the stream against a
// transaction-level reference: expected word sequence, issue order, buffer
// occupancy and handshake rules.
// ---------------------------------------------------------------------------
module tb_mesh_readback_sequencer;

    localparam int DW = 32;
    localparam int TE = 16;
    localparam int AW = 4;
    localparam int FD = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic          abort_i;
    logic          mesh_collection_complete_i;
    logic          mesh_read_enable_o;
    logic [AW-1:0] mesh_read_addr_o;
    logic [DW-1:0] mesh_read_data_i;
    logic          mesh_read_valid_i;
    logic          m_valid_o;
    logic [DW-1:0] m_data_o;
    logic          m_last_o;
    logic          m_ready_i;
    logic          busy_o;
    logic          done_o;
    logic          error_o;

    always #5 clk_i = ~clk_i;

    mesh_readback_sequencer #(
        .DATA_WIDTH (DW),
        .TOTAL_ELEMS(TE),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk_i                     (clk_i),
        .rst_i                     (rst_i),
        .start_i                   (start_i),
        .abort_i                   (abort_i),
        .mesh_collection_complete_i(mesh_collection_complete_i),
        .mesh_read_enable_o        (mesh_read_enable_o),
        .mesh_read_addr_o          (mesh_read_addr_o),
        .mesh_read_data_i          (mesh_read_data_i),
        .mesh_read_valid_i         (mesh_read_valid_i),
        .m_valid_o                 (m_valid_o),
        .m_data_o                  (m_data_o),
        .m_last_o                  (m_last_o),
        .m_ready_i                 (m_ready_i),
        .busy_o                    (busy_o),
        .done_o                    (done_o),
        .error_o                   (error_o)
    );

    int testsRun    = 0;
    int testsFailed = 0;
    int cyc         = 0;

    // Reference model state
    bit          pendRead     = 0;
    int          pendAddr     = 0;
    int          readsIssued  = 0;
    int          dropAt       = -1;
    bit          dropped      = 0;
    int          dropCycle    = -1;
    int          occ          = 0;
    int          expIdx       = 0;
    int          expAddr      = 0;
    int          doneCount    = 0;
    int          doneCyc      = -1;
    int          firstValidCyc = -1;
    bit          prevHold     = 0;
    bit          prevValid    = 0;
    bit          prevReady    = 0;
    logic [DW-1:0] prevData   = '0;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, observed, expected, cyc);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, let the mesh
    // answer the read issued last cycle, then sample and check outputs.
    task automatic applyStimulus(input bit st, input bit ab, input bit rs,
                                 input bit cmpl, input bit rdy);
        bit drove;
        bit dropNow;
        bit hs;
        bit infl;
        @(negedge clk_i);
        cyc++;
        start_i                    = st;
        abort_i                    = ab;
        rst_i                      = rs;
        mesh_collection_complete_i = cmpl;
        m_ready_i                  = rdy;
        drove   = 0;
        dropNow = 0;
        if (pendRead && readsIssued == dropAt && !dropped) begin
            dropped           = 1;
            dropNow           = 1;
            dropCycle         = cyc;
            mesh_read_valid_i = 1'b0;
            mesh_read_data_i  = $urandom;
        end else if (pendRead) begin
            mesh_read_valid_i = 1'b1;
            mesh_read_data_i  = DW'(pendAddr + 100);
            drove             = 1;
        end else begin
            mesh_read_valid_i = 1'b0;
            mesh_read_data_i  = $urandom;
        end
        #1;
        infl = pendRead;
        checkOutput("valid_vs_occupancy", m_valid_o, occ != 0);
        if (prevHold && prevValid && !prevReady) begin
            checkOutput("hold_valid", m_valid_o, 1);
            checkOutput("hold_data", m_data_o, prevData);
        end
        if (ab || dropNow) begin
            checkOutput("no_read_on_abort_or_error", mesh_read_enable_o, 0);
        end
        if (mesh_read_enable_o) begin
            checkOutput("read_addr_order", mesh_read_addr_o, expAddr);
            checkOutput("read_credit", (occ + int'(infl)) < FD, 1);
            expAddr++;
            readsIssued++;
        end
        if (m_valid_o) begin
            checkOutput("last_flag", m_last_o, expIdx == TE - 1);
            if (firstValidCyc < 0) firstValidCyc = cyc;
        end
        hs = m_valid_o && rdy;
        if (hs) begin
            checkOutput("stream_data", m_data_o, 100 + expIdx);
            expIdx++;
        end
        if (done_o) begin
            doneCount++;
            doneCyc = cyc;
            checkOutput("done_after_all_words", expIdx, TE);
        end
        pendRead = mesh_read_enable_o && !ab && !rs;
        pendAddr = int'(mesh_read_addr_o);
        if (rs || ab || dropNow) occ = 0;
        else occ = occ + int'(drove) - int'(hs);
        prevHold  = !(rs || ab || dropNow);
        prevValid = m_valid_o;
        prevReady = rdy;
        prevData  = m_data_o;
    endtask

    // readyMode: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random.
    task automatic runJob(input int cmplDelay, input int readyMode, input int abortAt,
                          input int dropAtRead, input int rstAt, input bit restartInWait);
        bit rdy;
        int streamCyc;
        bit pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        expIdx = 0; expAddr = 0; readsIssued = 0; dropped = 0; dropCycle = -1;
        doneCount = 0; doneCyc = -1; firstValidCyc = -1; dropAt = dropAtRead;

        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < cmplDelay; i++) begin
            applyStimulus(restartInWait && i == 0, 0, 0, 0, 0);
            checkOutput("wait_busy", busy_o, 1);
            checkOutput("wait_no_read", mesh_read_enable_o, 0);
            checkOutput("wait_error_clear", error_o, 0);
        end
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("complete_cycle_busy", busy_o, 1);
        checkOutput("complete_cycle_error", error_o, 0);
        streamCyc = cyc + 1;

        for (int n = 0; n < 200; n++) begin
            if (readyMode == 0) rdy = 1;
            else if (readyMode == 1) rdy = pat[n % 4];
            else rdy = ($urandom_range(0, 9) < 6);

            if (abortAt >= 0 && expIdx == abortAt) begin
                applyStimulus(0, 1, 0, 0, 0);
                applyStimulus(0, 0, 0, 0, 0);
                checkOutput("abort_idle", busy_o, 0);
                checkOutput("abort_valid", m_valid_o, 0);
                checkOutput("abort_no_done", doneCount, 0);
                checkOutput("abort_error", error_o, 0);
                return;
            end
            if (rstAt >= 0 && expIdx == rstAt) begin
                applyStimulus(0, 0, 1, 0, 0);
                applyStimulus(0, 0, 0, 0, 0);
                checkOutput("reset_midjob_outputs",
                            {mesh_read_enable_o, mesh_read_addr_o, m_valid_o, m_data_o,
                             m_last_o, busy_o, done_o, error_o}, 0);
                return;
            end
            applyStimulus(0, 0, 0, 0, rdy);
            if (dropped && cyc == dropCycle + 1) begin
                checkOutput("drop_error", error_o, 1);
                checkOutput("drop_valid", m_valid_o, 0);
                checkOutput("drop_busy", busy_o, 1);
                for (int k = 0; k < 3; k++) begin
                    applyStimulus(0, 0, 0, 0, 1);
                    checkOutput("error_sticky", error_o, 1);
                    checkOutput("error_busy", busy_o, 1);
                end
                return;
            end
            if (doneCount > 0) break;
        end

        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("done_pulses", doneCount, 1);
        checkOutput("words_delivered", expIdx, TE);
        checkOutput("idle_after_done", busy_o, 0);
        checkOutput("error_after_done", error_o, 0);
        if (readyMode == 0) begin
            checkOutput("first_valid_latency", (firstValidCyc - streamCyc) <= 3, 1);
            checkOutput("job_latency", (doneCyc >= 0) && ((doneCyc - streamCyc) <= TE + 4), 1);
        end
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
        mesh_collection_complete_i = 1'b0; mesh_read_valid_i = 1'b0;
        mesh_read_data_i = '0; m_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("reset_outputs",
                    {mesh_read_enable_o, mesh_read_addr_o, m_valid_o, m_data_o,
                     m_last_o, busy_o, done_o, error_o}, 0);
        rst_i = 1'b0;

        $display("[TB] basic job");
        runJob(5, 0, -1, -1, -1, 0);
        $display("[TB] backpressure 1,0,0,1");
        runJob(3, 1, -1, -1, -1, 0);
        $display("[TB] abort after 6 words");
        runJob(2, 0, 6, -1, -1, 0);
        runJob(4, 0, -1, -1, -1, 0);
        $display("[TB] missing valid on read 3");
        runJob(1, 0, -1, 3, -1, 0);
        runJob(2, 1, -1, -1, -1, 0);
        $display("[TB] reset at word 9");
        runJob(0, 0, -1, -1, 9, 0);
        runJob(3, 0, -1, -1, -1, 1);
        $display("[TB] random backpressure jobs");
        for (int j = 0; j < 4; j++) begin
            runJob($urandom_range(0, 6), 2, -1, -1, -1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
